// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types, defaults and parity helper for the serial frame checker
package parity_pkg;

    typedef enum logic {
        RX_DATA = 1'b0,
        RX_PAR  = 1'b1
    } rx_state_t;

    localparam int DATA_W_DEF = 3;
    localparam int CNT_W_DEF  = 8;

    // One step of an XOR reduction; folding every frame bit through it yields 0 for good even parity.
    function automatic logic parity_fold(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

endpackage

// File: rtl/sat_err_counter.sv
// rtl/sat_err_counter.sv - saturating event counter with synchronous clear (clear and increment together give 1)
module sat_err_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/parity_frame_checker.sv
// rtl/parity_frame_checker.sv - serial even-parity frame receiver with single-entry output register
// Optional saturating bad-frame counter (err_clr/err_cnt ports) enabled by PARITY_ERR_CNT_EN.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    input  logic              sin_valid,
    output logic              sin_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready
`ifdef PARITY_ERR_CNT_EN
    ,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  err_cnt
`endif
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_t         state;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shift_reg;
    logic              run_xor;
    logic              accept;
    logic              complete;
    logic              frame_err;
    logic [DATA_W-1:0] shift_next;

    // The parity bit is the only bit that can be held off: it needs a free output slot.
    assign sin_ready  = (state == RX_DATA) || !out_valid || out_ready;
    assign accept     = sin_valid && sin_ready;
    assign complete   = accept && (state == RX_PAR);
    assign frame_err  = parity_fold(run_xor, sin);
    assign shift_next = (shift_reg << 1) | DATA_W'(sin);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RX_DATA;
            bit_idx   <= '0;
            shift_reg <= '0;
            run_xor   <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                case (state)
                    RX_DATA: begin
                        shift_reg <= shift_next;
                        run_xor   <= parity_fold(run_xor, sin);
                        if (bit_idx == IDX_W'(DATA_W - 1)) begin
                            bit_idx <= '0;
                            state   <= RX_PAR;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                    RX_PAR: begin
                        out_data  <= shift_reg;
                        out_err   <= frame_err;
                        shift_reg <= '0;
                        run_xor   <= 1'b0;
                        bit_idx   <= '0;
                        state     <= RX_DATA;
                    end
                    default: state <= RX_DATA;
                endcase
            end
            // A completion in the same cycle as a drain refills the slot without a bubble.
            if (complete) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef PARITY_ERR_CNT_EN
    sat_err_counter #(
        .CNT_W(CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (complete && frame_err),
        .clr   (err_clr),
        .cnt   (err_cnt)
    );
`endif

endmodule
